// File: rtl/pe_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_sched_pkg
// Description : Shared definitions for the PE layer scheduler: the scheduler
//               state encoding and the default array dimensions.
// Contents    : c_PE_NUM_DEF, c_LAYER_W_DEF, c_DRAIN_CYC_DEF, sched_state_e
// Revision    : 1.0 - initial release
// ============================================================================
package pe_sched_pkg;

  localparam int c_PE_NUM_DEF    = 64;
  localparam int c_LAYER_W_DEF   = 4;
  localparam int c_DRAIN_CYC_DEF = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_FIN = 3'd2,
    DRAIN    = 3'd3,
    LDONE    = 3'd4,
    DONE     = 3'd5
  } sched_state_e;

endpackage : pe_sched_pkg
`default_nettype wire

// File: rtl/pe_fin_tracker.sv
`default_nettype none
// ============================================================================
// Module      : pe_fin_tracker
// Description : Collects per-PE finish pulses for the current layer, reports
//               when every active PE has finished and flags duplicate pulses.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_clr           - clear the finish vector (layer entry)
//               i_collect       - accumulate finish pulses (START/WAIT_FIN)
//               i_late          - any masked pulse is a duplicate (DRAIN/LDONE)
//               i_mask          - active-PE mask for the run
//               i_fin           - raw per-PE finish pulses
//               o_all_fin       - all active PEs finished (includes this cycle)
//               o_dup_err       - sticky duplicate-finish flag
// Revision    : 1.0 - initial release
// ============================================================================
module pe_fin_tracker
  import pe_sched_pkg::*;
#(
  parameter int PE_NUM = c_PE_NUM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_collect,
  input  logic              i_late,
  input  logic [PE_NUM-1:0] i_mask,
  input  logic [PE_NUM-1:0] i_fin,
  output logic              o_all_fin,
  output logic              o_dup_err
);

  logic [PE_NUM-1:0] r_fin;
  logic              r_dup_err;
  logic [PE_NUM-1:0] w_fin_masked;
  logic              w_dup;

  assign w_fin_masked = i_fin & i_mask;

  // Pulses arriving this very cycle count, so the layer can close on the
  // same cycle the last PE reports.
  assign o_all_fin = (((r_fin | i_fin) & i_mask) == i_mask);

  // After the layer has closed (DRAIN/LDONE) every masked pulse is a repeat.
  assign w_dup = (i_collect && (|(w_fin_masked & r_fin))) ||
                 (i_late && (|w_fin_masked));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fin     <= '0;
      r_dup_err <= 1'b0;
    end else begin
      if (i_clr) begin
        r_fin <= '0;
      end else if (i_collect) begin
        r_fin <= r_fin | w_fin_masked;
      end
      if (w_dup) begin
        r_dup_err <= 1'b1;
      end
    end
  end

  assign o_dup_err = r_dup_err;

endmodule : pe_fin_tracker
`default_nettype wire

// File: rtl/pe_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pe_layer_scheduler
// Description : Global layer scheduler. Broadcasts a start pulse per layer,
//               waits for all active PEs to finish, waits a drain interval,
//               then pulses layer_done and advances to the next layer.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - host run request (pulse)
//               layer_no        - total layer count, sampled on start
//               pe_active_mask  - participating PEs, sampled on start
//               pe_fin_comp     - per-PE finish pulses
//               pe_start_calc   - start-calculation broadcast pulse
//               layer_done      - layer-complete broadcast pulse
//               layer_idx       - current layer index
//               busy            - scheduler not idle
//               done            - run-complete pulse
//               dup_err         - sticky duplicate-finish flag
// Revision    : 1.0 - initial release
// ============================================================================
module pe_layer_scheduler
  import pe_sched_pkg::*;
#(
  parameter int PE_NUM    = c_PE_NUM_DEF,
  parameter int LAYER_W   = c_LAYER_W_DEF,
  parameter int DRAIN_CYC = c_DRAIN_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer_no,
  input  logic [PE_NUM-1:0]  pe_active_mask,
  input  logic [PE_NUM-1:0]  pe_fin_comp,
  output logic               pe_start_calc,
  output logic               layer_done,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               dup_err
);

  // A zero drain interval still needs a legal (1-bit) counter declaration.
  localparam int               c_CNT_W      = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'((DRAIN_CYC > 0) ? (DRAIN_CYC - 1) : 0);
  localparam bit               c_HAS_DRAIN  = (DRAIN_CYC > 0);

  sched_state_e       r_state;
  sched_state_e       w_state_nxt;
  logic [PE_NUM-1:0]  r_mask;
  logic [LAYER_W-1:0] r_layer_no;
  logic [LAYER_W-1:0] r_layer_idx;
  logic [c_CNT_W-1:0] r_drain_cnt;

  logic w_accept;
  logic w_all_fin;
  logic w_last_layer;
  logic w_collect;
  logic w_late;
  logic w_clr;

  assign w_accept     = (r_state == IDLE) && start;
  assign w_last_layer = (r_layer_idx == (r_layer_no - LAYER_W'(1)));
  assign w_collect    = (r_state == START) || (r_state == WAIT_FIN);
  assign w_late       = (r_state == DRAIN) || (r_state == LDONE);
  // START is only ever entered from IDLE or LDONE, so "next is START"
  // uniquely marks the entry edge.
  assign w_clr        = (w_state_nxt == START);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (layer_no != '0) ? START : DONE;
        end
      end
      START: begin
        w_state_nxt = WAIT_FIN;
      end
      WAIT_FIN: begin
        if (w_all_fin) begin
          w_state_nxt = c_HAS_DRAIN ? DRAIN : LDONE;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == c_DRAIN_LAST) begin
          w_state_nxt = LDONE;
        end
      end
      LDONE: begin
        w_state_nxt = w_last_layer ? DONE : START;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_layer_no  <= '0;
      r_layer_idx <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_mask      <= pe_active_mask;
        r_layer_no  <= layer_no;
        r_layer_idx <= '0;
      end else if ((r_state == LDONE) && (w_state_nxt == START)) begin
        r_layer_idx <= r_layer_idx + LAYER_W'(1);
      end

      if ((r_state == WAIT_FIN) && (w_state_nxt == DRAIN)) begin
        r_drain_cnt <= '0;
      end else if (r_state == DRAIN) begin
        r_drain_cnt <= r_drain_cnt + c_CNT_W'(1);
      end
    end
  end

  pe_fin_tracker #(
    .PE_NUM (PE_NUM)
  ) u_fin_tracker (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_collect (w_collect),
    .i_late    (w_late),
    .i_mask    (r_mask),
    .i_fin     (pe_fin_comp),
    .o_all_fin (w_all_fin),
    .o_dup_err (dup_err)
  );

  assign pe_start_calc = (r_state == START);
  assign layer_done    = (r_state == LDONE);
  assign done          = (r_state == DONE);
  assign busy          = (r_state != IDLE);
  assign layer_idx     = r_layer_idx;

endmodule : pe_layer_scheduler
`default_nettype wire

// File: tb/tb_pe_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_layer_scheduler
// Description : Scoreboard bench for pe_layer_scheduler. Each run is planned
//               up front from the layer/finish/drain timing rules, the planned
//               pulse events are queued, and a monitor matches every observed
//               output pulse (kind, cycle, layer index) against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_layer_scheduler;

  localparam int PE_NUM    = 64;
  localparam int LAYER_W   = 4;
  localparam int DRAIN_CYC = 4;

  localparam int K_START = 0;
  localparam int K_LDONE = 1;
  localparam int K_DONE  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [LAYER_W-1:0] layer_no;
  logic [PE_NUM-1:0]  pe_active_mask;
  logic [PE_NUM-1:0]  pe_fin_comp;
  logic               pe_start_calc;
  logic               layer_done;
  logic [LAYER_W-1:0] layer_idx;
  logic               busy;
  logic               done;
  logic               dup_err;

  typedef struct {
    int kind;
    int cyc;
    int idx;
  } ev_t;

  ev_t               exp_q[$];
  logic [PE_NUM-1:0] sched [int];
  int                cyc   = 0;
  int                tests = 0;
  int                fails = 0;
  bit                exp_dup = 1'b0;

  pe_layer_scheduler #(
    .PE_NUM    (PE_NUM),
    .LAYER_W   (LAYER_W),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .layer_no       (layer_no),
    .pe_active_mask (pe_active_mask),
    .pe_fin_comp    (pe_fin_comp),
    .pe_start_calc  (pe_start_calc),
    .layer_done     (layer_done),
    .layer_idx      (layer_idx),
    .busy           (busy),
    .done           (done),
    .dup_err        (dup_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: matches every output pulse against the planned event queue.
  always @(negedge clk) begin
    int nh;
    int kind;
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missed_event: kind %0d expected at cycle %0d idx %0d, not seen (now cycle %0d)",
               e.kind, e.cyc, e.idx, cyc);
    end
    nh = int'(pe_start_calc) + int'(layer_done) + int'(done);
    if (nh > 1) begin
      tests++;
      fails++;
      $display("FAIL pulse_overlap: cycle %0d start_calc=%0b layer_done=%0b done=%0b, required at most one",
               cyc, pe_start_calc, layer_done, done);
    end
    if (nh != 0) begin
      kind = pe_start_calc ? K_START : (layer_done ? K_LDONE : K_DONE);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: kind %0d at cycle %0d idx %0d, required none", kind, cyc, layer_idx);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.idx != int'(layer_idx) || !busy) begin
          fails++;
          $display("FAIL event: got kind %0d cycle %0d idx %0d busy %0b, required kind %0d cycle %0d idx %0d busy 1",
                   kind, cyc, layer_idx, busy, e.kind, e.cyc, e.idx);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int idx);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  // Plans one run from the timing rules, then drives it cycle by cycle.
  //   fixed_off >= 0 : every active PE finishes that many cycles after start_calc
  //   inj_dup        : PE 3 pulses a second time in layer 0
  //   busy_start     : second start during the START cycle, lowest active PE
  //                    finishes inside the START cycle
  //   abort_layer    : reset asserted mid-DRAIN of that layer (-1: none)
  task automatic run(input int nl, input logic [PE_NUM-1:0] mask, input int fixed_off,
                     input int max_off, input bit inj_dup, input bit busy_start,
                     input int abort_layer);
    int   c0, s, t, ci, off, ldone, endc, abort_c, first_pe;
    ev_t  keep[$];
    sched.delete();
    c0      = cyc;
    abort_c = -1;
    first_pe = -1;
    for (int i = 0; i < PE_NUM; i++) begin
      if (mask[i] && first_pe < 0) first_pe = i;
    end
    if (nl == 0) begin
      push_ev(K_DONE, c0 + 1, 0);
      endc = c0 + 2;
    end else begin
      s = c0 + 1;
      for (int k = 0; k < nl; k++) begin
        t = s + 1;  // WAIT_FIN is always visited at least once
        for (int i = 0; i < PE_NUM; i++) begin
          if (mask[i]) begin
            off = (fixed_off >= 0) ? fixed_off : $urandom_range(0, max_off);
            if (busy_start && i == first_pe) off = 0;
            ci = s + off;
            sched[ci] = (sched.exists(ci) ? sched[ci] : '0) | (64'd1 << i);
            if (ci > t) t = ci;
            if (inj_dup && k == 0 && i == 3) begin
              sched[ci + 1] = (sched.exists(ci + 1) ? sched[ci + 1] : '0) | (64'd1 << 3);
              exp_dup = 1'b1;
            end
          end
        end
        if (!mask[0]) begin
          sched[s + 1] = (sched.exists(s + 1) ? sched[s + 1] : '0) | 64'd1;
        end
        push_ev(K_START, s, k);
        ldone = t + 1 + DRAIN_CYC;
        push_ev(K_LDONE, ldone, k);
        if (k == abort_layer) abort_c = ldone - 2;
        s = ldone + 1;
      end
      push_ev(K_DONE, s, nl - 1);
      endc = s + 1;
    end
    if (abort_c >= 0) begin
      keep = {};
      foreach (exp_q[j]) if (exp_q[j].cyc <= abort_c) keep.push_back(exp_q[j]);
      exp_q   = keep;
      endc    = abort_c + 1;
      exp_dup = 1'b0;
    end
    // Noise from non-participating PEs must never influence anything.
    for (int c = c0; c < endc; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        sched[c] = (sched.exists(c) ? sched[c] : '0) | (~mask & {$urandom, $urandom});
      end
    end
    while (cyc < endc) begin
      start          = (cyc == c0) || (busy_start && cyc == c0 + 1);
      layer_no       = (cyc == c0) ? LAYER_W'(nl) : LAYER_W'($urandom);
      pe_active_mask = (cyc == c0) ? mask : {$urandom, $urandom};
      pe_fin_comp    = sched.exists(cyc) ? sched[cyc] : '0;
      rst            = (cyc == abort_c);
      step();
    end
    start       = 1'b0;
    pe_fin_comp = '0;
    rst         = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("busy_after_run", 64'(busy), 64'd0);
    check("dup_err_after_run", 64'(dup_err), 64'(exp_dup));
    if (abort_c >= 0) begin
      check("idx_after_reset", 64'(layer_idx), 64'd0);
      check("outs_after_reset", {61'd0, pe_start_calc, layer_done, done}, 64'd0);
    end else begin
      check("idx_hold", 64'(layer_idx), (nl == 0) ? 64'd0 : 64'(nl - 1));
    end
    step();
  endtask

  initial begin
    int nl;
    logic [PE_NUM-1:0] m;
    rst            = 1'b1;
    start          = 1'b0;
    layer_no       = '0;
    pe_active_mask = '0;
    pe_fin_comp    = '0;
    repeat (3) step();
    check("reset_outs", {58'd0, pe_start_calc, layer_done, busy, done, dup_err, 1'b0}, 64'd0);
    check("reset_idx", 64'(layer_idx), 64'd0);
    rst = 1'b0;
    step();

    run(3, '1, 10, 0, 1'b0, 1'b0, -1);                          // all PEs, fixed latency
    run(1, 64'h0000_0000_0000_00F0, -1, 12, 1'b0, 1'b0, -1);    // partial mask, PE0 ignored
    run(0, '1, -1, 5, 1'b0, 1'b0, -1);                          // zero layers
    run(2, 64'h0000_0000_0000_00FF, -1, 6, 1'b1, 1'b0, -1);     // duplicate from PE 3
    run(2, '1, -1, 6, 1'b0, 1'b0, -1);                          // dup_err stays sticky
    run(3, '1, -1, 6, 1'b0, 1'b0, 1);                           // reset mid-DRAIN
    run(2, 64'h8000_0000_0001_0004, -1, 5, 1'b0, 1'b1, -1);     // start while busy
    run(2, '0, -1, 3, 1'b0, 1'b0, -1);                          // empty mask

    for (int r = 0; r < 8; r++) begin
      nl = $urandom_range(1, 5);
      m  = ($urandom_range(0, 4) == 0) ? '0 : ({$urandom, $urandom} & {$urandom, $urandom});
      run(nl, m, -1, $urandom_range(0, 15), 1'b0, r[0], -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pe_layer_scheduler
`default_nettype wire
